// File: rtl/if_fetch_queue.sv
// -----------------------------------------------------------------------------
// if_fetch_queue
//
// Instruction-fetch stage with a decoupling queue in front of decode. It owns
// the fetch PC, picks the next PC among sequential / branch / jump / register /
// interrupt / exception / error targets, and buffers up to QUEUE_DEPTH fetched
// {instruction, PC+4} pairs so fetch keeps running while decode stalls.
//
// Ports:
//   clk             in   1   clock, all state updates on the rising edge
//   rst_n           in   1   synchronous active-low reset
//   fetch_en        in   1   permits sequential fetch (hazard-unit PCWrite)
//   pc_sel          in   3   0 seq, 1 branch, 2 jump, 3 jr, 4 irq, 5 exc, 6/7 err
//   branch_target   in  32   redirect target for pc_sel=1
//   jump_target     in  32   redirect target for pc_sel=2
//   jr_target       in  32   redirect target for pc_sel=3
//   imem_addr       out 32   instruction memory address (== pc)
//   imem_rdata      in  32   instruction at imem_addr, combinational
//   imem_valid      in   1   imem_rdata is valid this cycle
//   id_valid        out  1   queue head valid
//   id_ready        in   1   decode accepts the head this cycle
//   id_instruction  out 32   head instruction, 0 when empty
//   id_pc_plus_4    out 32   head PC+4, 0 when empty
//   pc              out 32   current fetch PC
//   queue_count     out CW   queue occupancy, CW = $clog2(QUEUE_DEPTH)+1
//   queue_full      out  1   queue_count == QUEUE_DEPTH
//
// Handshake (decode side): the head entry transfers on a rising edge where
// id_valid && id_ready are both high. id_valid never depends on id_ready, and
// the head stays stable until it is transferred or a redirect flushes it.
// On the memory side a word is consumed on an edge where imem_valid is high,
// fetch is enabled, no redirect is requested and the queue has (or is making)
// room; otherwise imem_rdata is ignored and the PC holds.
// -----------------------------------------------------------------------------
module if_fetch_queue #(
  parameter int          QUEUE_DEPTH  = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
  parameter logic [31:0] IRQ_VECTOR   = 32'h8000_0004,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0008,
  parameter logic [31:0] ERROR_VECTOR = 32'hFFFF_FFFF,
  parameter bit          PRESERVE_MSB = 1'b1,
  localparam int         PW           = $clog2(QUEUE_DEPTH),
  localparam int         CW           = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_en,
  input  logic [2:0]    pc_sel,
  input  logic [31:0]   branch_target,
  input  logic [31:0]   jump_target,
  input  logic [31:0]   jr_target,
  output logic [31:0]   imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          imem_valid,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [31:0]   id_instruction,
  output logic [31:0]   id_pc_plus_4,
  output logic [31:0]   pc,
  output logic [CW-1:0] queue_count,
  output logic          queue_full
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(QUEUE_DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Payload storage; contents are qualified by count_q and need no reset.
  logic [31:0] instr_mem_q [QUEUE_DEPTH];
  logic [31:0] pcp4_mem_q  [QUEUE_DEPTH];

  // ---------------------------------------------------------------------------
  // Sequential PC. With PRESERVE_MSB the kernel bit PC[31] is held and only
  // the low 31 bits increment, so the address space wraps within its half.
  // ---------------------------------------------------------------------------
  logic [31:0] pc_plus_4;

  generate
    if (PRESERVE_MSB) begin : g_keep_msb
      assign pc_plus_4 = {pc_q[31], pc_q[30:0] + 31'd4};
    end else begin : g_full_add
      assign pc_plus_4 = pc_q + 32'd4;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Redirect target selection
  // ---------------------------------------------------------------------------
  logic        redirect;
  logic [31:0] redirect_pc;

  assign redirect = (pc_sel != 3'd0);

  always_comb begin
    redirect_pc = ERROR_VECTOR;
    case (pc_sel)
      3'd1:    redirect_pc = branch_target;
      3'd2:    redirect_pc = jump_target;
      3'd3:    redirect_pc = jr_target;
      3'd4:    redirect_pc = IRQ_VECTOR;
      3'd5:    redirect_pc = EXC_VECTOR;
      default: redirect_pc = ERROR_VECTOR;  // 6, 7 (0 is never used: no redirect)
    endcase
  end

  // ---------------------------------------------------------------------------
  // Queue control
  // ---------------------------------------------------------------------------
  logic full;
  logic empty;
  logic pop;
  logic push;

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);

  // A redirect flushes the queue, so any pop or push in that cycle is moot.
  assign pop  = ~empty & id_ready & ~redirect;
  // A full queue can still accept a word when the head leaves on the same edge.
  assign push = ~redirect & fetch_en & imem_valid & (~full | pop);

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (redirect) begin
      pc_d     = redirect_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_plus_4;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      // Pointers wrap naturally because QUEUE_DEPTH is a power of two.
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_VECTOR;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write is gated by rst_n so a reset edge never commits a word.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pcp4_mem_q[wr_ptr_q]  <= pc_plus_4;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. An empty queue presents a zero bubble to decode.
  // ---------------------------------------------------------------------------
  assign pc             = pc_q;
  assign imem_addr      = pc_q;
  assign queue_count    = count_q;
  assign queue_full     = full;
  assign id_valid       = ~empty;
  assign id_instruction = empty ? 32'h0 : instr_mem_q[rd_ptr_q];
  assign id_pc_plus_4   = empty ? 32'h0 : pcp4_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_if_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_queue
//
// Directed bench for if_fetch_queue with default parameters (depth 4,
// PRESERVE_MSB=1). Instruction memory is a pure function of the address so
// every expected word can be written down from the PC alone.
// -----------------------------------------------------------------------------
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [2:0]  pc_sel;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instruction;
  logic [31:0] id_pc_plus_4;
  logic [31:0] pc;
  logic [2:0]  queue_count;
  logic        queue_full;

  int n_checks = 0;
  int n_errors = 0;

  if_fetch_queue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .pc_sel         (pc_sel),
    .branch_target  (branch_target),
    .jump_target    (jump_target),
    .jr_target      (jr_target),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_valid     (imem_valid),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instruction (id_instruction),
    .id_pc_plus_4   (id_pc_plus_4),
    .pc             (pc),
    .queue_count    (queue_count),
    .queue_full     (queue_full)
  );

  // ---------------------------------------------------------------------------
  // Clock / memory model
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] addr);
    return {addr[15:0], ~addr[15:0]};
  endfunction

  assign imem_rdata = word_of(imem_addr);

  // ---------------------------------------------------------------------------
  // Driver / checker tasks
  // ---------------------------------------------------------------------------
  // Advance one rising edge and settle 1 ns past it before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic check_q(input string tag, input int cnt, input logic [31:0] exp_pc);
    check({tag, ".count"}, {29'd0, queue_count}, cnt);
    check({tag, ".pc"}, pc, exp_pc);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; pc_sel = 3'd0; imem_valid = 1'b0; id_ready = 1'b0;
    branch_target = 32'h0; jump_target = 32'h0; jr_target = 32'h0;
    #1;
    step();
    step();

    // Reset state
    check("rst.pc", pc, 32'h8000_0000);
    check("rst.count", {29'd0, queue_count}, 32'd0);
    check("rst.id_valid", {31'd0, id_valid}, 32'd0);
    check("rst.id_instr", id_instruction, 32'h0);
    check("rst.id_pc4", id_pc_plus_4, 32'h0);
    check("rst.full", {31'd0, queue_full}, 32'd0);
    check("rst.imem_addr", imem_addr, 32'h8000_0000);

    // Fill: one push per edge, nothing drained
    rst_n = 1'b1; fetch_en = 1'b1; imem_valid = 1'b1; id_ready = 1'b0;
    step();
    check_q("fill1", 1, 32'h8000_0004);
    check("fill1.id_valid", {31'd0, id_valid}, 32'd1);
    check("fill1.id_instr", id_instruction, word_of(32'h8000_0000));
    check("fill1.id_pc4", id_pc_plus_4, 32'h8000_0004);
    step(); step(); step();
    check_q("fill4", 4, 32'h8000_0010);
    check("fill4.full", {31'd0, queue_full}, 32'd1);
    // Full without pop: fetch stalls, head unchanged
    step();
    check_q("stall", 4, 32'h8000_0010);
    check("stall.id_instr", id_instruction, word_of(32'h8000_0000));
    check("stall.id_pc4", id_pc_plus_4, 32'h8000_0004);

    // Stream: full with pop, push+pop each edge
    id_ready = 1'b1;
    step();
    check_q("strm1", 4, 32'h8000_0014);
    check("strm1.id_pc4", id_pc_plus_4, 32'h8000_0008);
    step();
    check_q("strm2", 4, 32'h8000_0018);
    check("strm2.id_pc4", id_pc_plus_4, 32'h8000_000C);
    step();
    check_q("strm3", 4, 32'h8000_001C);
    check("strm3.id_pc4", id_pc_plus_4, 32'h8000_0010);
    check("strm3.id_instr", id_instruction, word_of(32'h8000_000C));
    check("strm3.full", {31'd0, queue_full}, 32'd1);

    // Drain one with fetch disabled -> 3 entries, pc holds
    fetch_en = 1'b0;
    step();
    check_q("drain", 3, 32'h8000_001C);
    check("drain.id_pc4", id_pc_plus_4, 32'h8000_0014);

    // Branch redirect with 3 entries queued and decode ready
    fetch_en = 1'b1; pc_sel = 3'd1; branch_target = 32'h8000_0100;
    step();
    check_q("br", 0, 32'h8000_0100);
    check("br.id_valid", {31'd0, id_valid}, 32'd0);
    check("br.id_instr", id_instruction, 32'h0);
    check("br.id_pc4", id_pc_plus_4, 32'h0);
    pc_sel = 3'd0; id_ready = 1'b0;
    step();
    check_q("br_tgt", 1, 32'h8000_0104);
    check("br_tgt.id_pc4", id_pc_plus_4, 32'h8000_0104);
    check("br_tgt.id_instr", id_instruction, word_of(32'h8000_0100));

    // Jump / jr / vectors; redirects ignore fetch_en and never push
    fetch_en = 1'b0; pc_sel = 3'd2; jump_target = 32'h8000_0200;
    step();
    check_q("jmp", 0, 32'h8000_0200);
    pc_sel = 3'd3; jr_target = 32'h8000_0300;
    step();
    check_q("jr", 0, 32'h8000_0300);
    pc_sel = 3'd4;
    step();
    check_q("irq", 0, 32'h8000_0004);
    pc_sel = 3'd5;
    step();
    check_q("exc", 0, 32'h8000_0008);
    fetch_en = 1'b1; imem_valid = 1'b1; pc_sel = 3'd7;
    step();
    check_q("err7", 0, 32'hFFFF_FFFF);
    pc_sel = 3'd2; jump_target = 32'h8000_0300;
    step();
    pc_sel = 3'd6;
    step();
    check_q("err6", 0, 32'hFFFF_FFFF);
    check("err6.id_valid", {31'd0, id_valid}, 32'd0);

    // Memory wait: one entry, then imem_valid low for 3 cycles
    pc_sel = 3'd2; jump_target = 32'h8000_0040;
    step();
    pc_sel = 3'd0; fetch_en = 1'b1; imem_valid = 1'b1; id_ready = 1'b0;
    step();
    check_q("mw0", 1, 32'h8000_0044);
    imem_valid = 1'b0;
    step(); step(); step();
    check_q("mw3", 1, 32'h8000_0044);
    check("mw3.id_pc4", id_pc_plus_4, 32'h8000_0044);
    // Pops continue while memory waits
    id_ready = 1'b1;
    step();
    check_q("mw_pop", 0, 32'h8000_0044);
    // Empty with id_ready high: no pop, count stays 0
    step();
    check_q("empty_rdy", 0, 32'h8000_0044);
    check("empty_rdy.id_valid", {31'd0, id_valid}, 32'd0);

    // Wrap with kernel bit preserved
    id_ready = 1'b0; fetch_en = 1'b0; pc_sel = 3'd2; jump_target = 32'hFFFF_FFFC;
    step();
    check_q("wrap_set", 0, 32'hFFFF_FFFC);
    pc_sel = 3'd0; fetch_en = 1'b1; imem_valid = 1'b1;
    step();
    check_q("wrap_hi", 1, 32'h8000_0000);
    check("wrap_hi.id_pc4", id_pc_plus_4, 32'h8000_0000);
    check("wrap_hi.id_instr", id_instruction, word_of(32'hFFFF_FFFC));
    fetch_en = 1'b0; pc_sel = 3'd2; jump_target = 32'h7FFF_FFFC;
    step();
    pc_sel = 3'd0; fetch_en = 1'b1;
    step();
    check_q("wrap_lo", 1, 32'h0000_0000);
    check("wrap_lo.id_pc4", id_pc_plus_4, 32'h0000_0000);

    // Reset mid-traffic: two more pushes, then rst_n low for 2 edges
    step(); step();
    check_q("pre_rst", 3, 32'h0000_0008);
    rst_n = 1'b0; id_ready = 1'b1;
    step();
    check_q("mrst1", 0, 32'h8000_0000);
    check("mrst1.id_valid", {31'd0, id_valid}, 32'd0);
    check("mrst1.id_instr", id_instruction, 32'h0);
    check("mrst1.full", {31'd0, queue_full}, 32'd0);
    step();
    check_q("mrst2", 0, 32'h8000_0000);
    rst_n = 1'b1; id_ready = 1'b0;
    step();
    check_q("post_rst", 1, 32'h8000_0004);
    check("post_rst.id_instr", id_instruction, word_of(32'h8000_0000));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
